// File: rtl/collision_scheduler_pkg.sv
// Shared constants and state encoding for the per-frame collision scheduler.
package collision_scheduler_pkg;

   localparam int DEF_NUM_WALLS = 4;
   localparam int DEF_X_W       = 9;
   localparam int DEF_Y_W       = 8;
   localparam int DEF_WALL_W    = 20;
   localparam int DEF_FLOOR_Y   = 230;

   // hit_index when the scan found nothing; the boundary index equals NUM_WALLS
   localparam int NO_HIT_INDEX  = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   function automatic int boundary_index(input int num_walls);
      return num_walls;
   endfunction

endpackage

// File: rtl/collision_scheduler_if.sv
// Bird/wall inputs and scan results exchanged between the game core and the scheduler.
interface collision_scheduler_if #(
   parameter int NUM_WALLS = 4,
   parameter int X_W       = 9,
   parameter int Y_W       = 8
);
   localparam int IDX_W = $clog2(NUM_WALLS + 1);

   logic                     frame_tick;
   logic                     restart;
   logic [X_W-1:0]           bird_xleft;
   logic [X_W-1:0]           bird_xright;
   logic [Y_W-1:0]           bird_ytop;
   logic [Y_W-1:0]           bird_ybottom;
   logic [NUM_WALLS*X_W-1:0] wall_xleft;
   logic [NUM_WALLS*Y_W-1:0] wall_gap_top;
   logic [NUM_WALLS*Y_W-1:0] wall_gap_bot;
   logic [NUM_WALLS-1:0]     wall_valid;
   logic                     busy;
   logic                     done;
   logic                     hit;
   logic [IDX_W-1:0]         hit_index;
   logic                     game_over;
   logic                     overrun;

   modport master (
      output frame_tick, restart, bird_xleft, bird_xright, bird_ytop, bird_ybottom,
             wall_xleft, wall_gap_top, wall_gap_bot, wall_valid,
      input  busy, done, hit, hit_index, game_over, overrun
   );

   modport slave (
      input  frame_tick, restart, bird_xleft, bird_xright, bird_ytop, bird_ybottom,
             wall_xleft, wall_gap_top, wall_gap_bot, wall_valid,
      output busy, done, hit, hit_index, game_over, overrun
   );
endinterface

// File: rtl/collision_scheduler_overlap.sv
// Combinational box-vs-wall test: bird overlaps the wall columns and lies outside the gap.
module wall_overlap_check #(
   parameter int X_W    = 9,
   parameter int Y_W    = 8,
   parameter int WALL_W = 20
) (
   input  logic [X_W-1:0] i_bird_xleft,
   input  logic [X_W-1:0] i_bird_xright,
   input  logic [Y_W-1:0] i_bird_ytop,
   input  logic [Y_W-1:0] i_bird_ybottom,
   input  logic [X_W-1:0] i_wall_xleft,
   input  logic [Y_W-1:0] i_gap_top,
   input  logic [Y_W-1:0] i_gap_bot,
   output logic           o_overlap
);
   // One extra bit so the right wall edge near the screen end cannot wrap
   logic [X_W:0] w_wall_xright;
   logic         w_x_overlap;
   logic         w_y_outside;

   assign w_wall_xright = {1'b0, i_wall_xleft} + (X_W+1)'(WALL_W - 1);
   assign w_x_overlap   = ({1'b0, i_bird_xright} >= {1'b0, i_wall_xleft}) &&
                          ({1'b0, i_bird_xleft} <= w_wall_xright);
   assign w_y_outside   = (i_bird_ytop <= i_gap_top) || (i_bird_ybottom >= i_gap_bot);
   assign o_overlap     = w_x_overlap && w_y_outside;
endmodule

// File: rtl/collision_scheduler.sv
// Per-frame collision sequencer: snapshot, one-wall-per-cycle scan, first-hit report, sticky game_over.
module collision_scheduler
   import collision_scheduler_pkg::*;
#(
   parameter int NUM_WALLS = DEF_NUM_WALLS,
   parameter int X_W       = DEF_X_W,
   parameter int Y_W       = DEF_Y_W,
   parameter int WALL_W    = DEF_WALL_W,
   parameter int FLOOR_Y   = DEF_FLOOR_Y
) (
   input  logic                  clk,
   input  logic                  reset,
   collision_scheduler_if.slave  bus
);
   localparam int               IDX_W        = $clog2(NUM_WALLS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_WALLS - 1);
   localparam logic [IDX_W-1:0] BOUNDARY_IDX = IDX_W'(boundary_index(NUM_WALLS));
   localparam logic [IDX_W-1:0] NO_HIT_IDX   = IDX_W'(NO_HIT_INDEX);

   state_t               r_state;
   logic [IDX_W-1:0]     r_idx;
   logic [X_W-1:0]       r_bird_xl;
   logic [X_W-1:0]       r_bird_xr;
   logic [Y_W-1:0]       r_bird_yt;
   logic [Y_W-1:0]       r_bird_yb;
   logic [X_W-1:0]       r_wall_xl  [NUM_WALLS];
   logic [Y_W-1:0]       r_gap_top  [NUM_WALLS];
   logic [Y_W-1:0]       r_gap_bot  [NUM_WALLS];
   logic [NUM_WALLS-1:0] r_wall_valid;
   logic                 r_stage_valid;
   logic                 r_stage_hit;
   logic [IDX_W-1:0]     r_stage_idx;
   logic                 r_acc_hit;
   logic [IDX_W-1:0]     r_acc_idx;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_hit;
   logic [IDX_W-1:0]     r_hit_index;
   logic                 r_game_over;
   logic                 r_overrun;

   logic [X_W-1:0]       w_sel_xl;
   logic [Y_W-1:0]       w_sel_gap_top;
   logic [Y_W-1:0]       w_sel_gap_bot;
   logic                 w_sel_valid;
   logic                 w_overlap;
   logic                 w_boundary;
   logic                 w_report_hit;

   // Route the snapshot of wall r_idx to the single shared comparator
   always_comb begin
      w_sel_xl      = '0;
      w_sel_gap_top = '0;
      w_sel_gap_bot = '0;
      w_sel_valid   = 1'b0;
      for (int i = 0; i < NUM_WALLS; i++) begin
         w_sel_xl      = (r_idx == IDX_W'(i)) ? r_wall_xl[i]    : w_sel_xl;
         w_sel_gap_top = (r_idx == IDX_W'(i)) ? r_gap_top[i]    : w_sel_gap_top;
         w_sel_gap_bot = (r_idx == IDX_W'(i)) ? r_gap_bot[i]    : w_sel_gap_bot;
         w_sel_valid   = (r_idx == IDX_W'(i)) ? r_wall_valid[i] : w_sel_valid;
      end
   end

   wall_overlap_check #(
      .X_W    (X_W),
      .Y_W    (Y_W),
      .WALL_W (WALL_W)
   ) u_overlap (
      .i_bird_xleft   (r_bird_xl),
      .i_bird_xright  (r_bird_xr),
      .i_bird_ytop    (r_bird_yt),
      .i_bird_ybottom (r_bird_yb),
      .i_wall_xleft   (w_sel_xl),
      .i_gap_top      (w_sel_gap_top),
      .i_gap_bot      (w_sel_gap_bot),
      .o_overlap      (w_overlap)
   );

   assign w_boundary   = (r_bird_yt == '0) || (r_bird_yb >= Y_W'(FLOOR_Y));
   assign w_report_hit = r_acc_hit || w_boundary;

   // Scan FSM with snapshot, stage, accumulator and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_idx         <= '0;
         r_bird_xl     <= '0;
         r_bird_xr     <= '0;
         r_bird_yt     <= '0;
         r_bird_yb     <= '0;
         for (int i = 0; i < NUM_WALLS; i++) begin
            r_wall_xl[i] <= '0;
            r_gap_top[i] <= '0;
            r_gap_bot[i] <= '0;
         end
         r_wall_valid  <= '0;
         r_stage_valid <= 1'b0;
         r_stage_hit   <= 1'b0;
         r_stage_idx   <= '0;
         r_acc_hit     <= 1'b0;
         r_acc_idx     <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_hit         <= 1'b0;
         r_hit_index   <= '0;
         r_game_over   <= 1'b0;
         r_overrun     <= 1'b0;
      end else if (bus.restart) begin
         // Abort: pending result is dropped, previous hit/hit_index are kept
         r_state       <= ST_IDLE;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_overrun     <= 1'b0;
         r_game_over   <= 1'b0;
         r_stage_valid <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_overrun <= bus.frame_tick && (r_state != ST_IDLE);

         // Walls arrive in ascending order, so the first hit folded is the lowest index
         if (r_stage_valid && r_stage_hit && !r_acc_hit) begin
            r_acc_hit <= 1'b1;
            r_acc_idx <= r_stage_idx;
         end else begin
            r_acc_hit <= r_acc_hit;
         end

         case (r_state)
            ST_IDLE: begin
               if (bus.frame_tick) begin
                  r_bird_xl <= bus.bird_xleft;
                  r_bird_xr <= bus.bird_xright;
                  r_bird_yt <= bus.bird_ytop;
                  r_bird_yb <= bus.bird_ybottom;
                  for (int i = 0; i < NUM_WALLS; i++) begin
                     r_wall_xl[i] <= bus.wall_xleft[i*X_W +: X_W];
                     r_gap_top[i] <= bus.wall_gap_top[i*Y_W +: Y_W];
                     r_gap_bot[i] <= bus.wall_gap_bot[i*Y_W +: Y_W];
                  end
                  r_wall_valid  <= bus.wall_valid;
                  r_acc_hit     <= 1'b0;
                  r_acc_idx     <= '0;
                  r_idx         <= '0;
                  r_stage_valid <= 1'b0;
                  r_busy        <= 1'b1;
                  r_state       <= ST_SCAN;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_SCAN: begin
               r_stage_valid <= 1'b1;
               r_stage_hit   <= w_sel_valid && w_overlap;
               r_stage_idx   <= r_idx;
               r_idx         <= r_idx + IDX_W'(1);
               if (r_idx == LAST_IDX) begin
                  r_state <= ST_DRAIN;
               end else begin
                  r_state <= ST_SCAN;
               end
            end
            ST_DRAIN: begin
               r_stage_valid <= 1'b0;
               r_state       <= ST_REPORT;
            end
            ST_REPORT: begin
               r_done      <= 1'b1;
               r_hit       <= w_report_hit;
               r_hit_index <= r_acc_hit ? r_acc_idx : (w_boundary ? BOUNDARY_IDX : NO_HIT_IDX);
               r_game_over <= r_game_over || w_report_hit;
               r_busy      <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.hit       = r_hit;
   assign bus.hit_index = r_hit_index;
   assign bus.game_over = r_game_over;
   assign bus.overrun   = r_overrun;
endmodule
